if_fetch_stage: RTL

Instruction-fetch stage directly upstream of the decode stage in the 5-stage MIPS pipeline. Owns the PC and drives a single-outstanding, SRAM-like request/response instruction bus. Presents one fetched instruction per handshake to the IF/ID boundary. Applies branch, jump and jr redirects from decode after the delay slot, and exception redirects immediately.

---
 rtl/if_pkg.sv | 22 ++
 rtl/if_fetch_stage_next_pc_gen.sv | 46 ++++
 rtl/if_fetch_stage.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
//   fetch_state_t    : fetch FSM state encoding
//   RESET_PC_DEFAULT : boot vector loaded into the PC on reset
//   NOP_INSTR        : value presented on if_instr_o when no valid instruction
//   jump_target()    : j/jal target from the ID-stage PC+4 and instr[25:0]
package if_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

  function automatic logic [31:0] jump_target(input logic [31:0] pc4,
                                              input logic [25:0] index);
    return {pc4[31:28], index, 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_stage_next_pc_gen.sv
// Combinational next-PC generator for the fetch stage.
// Inputs : pc, stall, ID redirect requests (branch/jump/jr with their
//          operands), the pending redirect register (redir_pend/redir_tgt).
// Outputs: redir_hit     - a redirect is being captured this cycle
//          redir_new_tgt - target of that redirect (jr > jump > branch)
//          next_pc       - PC to fetch after the instruction now in IF
module next_pc_gen
  import if_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        stall,
  input  logic        do_branch,
  input  logic [31:0] branch_addr,
  input  logic        jump_flag,
  input  logic [25:0] jump_index,
  input  logic        jr_flag,
  input  logic [31:0] rs_data,
  input  logic [31:0] id_pc4,
  input  logic        redir_pend,
  input  logic [31:0] redir_tgt,
  output logic        redir_hit,
  output logic [31:0] redir_new_tgt,
  output logic [31:0] next_pc
);

  always_comb begin
    redir_hit = (jr_flag | jump_flag | do_branch) & ~stall;

    if (jr_flag)
      redir_new_tgt = rs_data;
    else if (jump_flag)
      redir_new_tgt = jump_target(id_pc4, jump_index);
    else
      redir_new_tgt = branch_addr;

    // A redirect captured in the same cycle the delay slot is consumed
    // bypasses the pending register.
    if (redir_hit)
      next_pc = redir_new_tgt;
    else if (redir_pend)
      next_pc = redir_tgt;
    else
      next_pc = pc + 32'd4;
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage of the 5-stage MIPS pipeline.
// Owns the PC, issues single-outstanding requests on an SRAM-like
// instruction bus and hands one instruction at a time to IF/ID.
// Ports:
//   clk_i, rst_i (sync, active-high)
//   if_stall_i                      - IF/ID not accepting this cycle
//   exc_flush_i, exc_pc_i           - exception/eret redirect, immediate
//   id_* redirect inputs            - branch/j/jal/jr/jalr from decode,
//                                     applied after the delay slot
//   inst_req_o/inst_addr_o/inst_addr_ok_i/inst_data_ok_i/inst_rdata_i - bus
//   if_valid_o/if_instr_o/if_pc_o/if_pc4_o/if_adel_o - IF/ID interface
//   fetch_busy_o                    - fetch in flight
//
// state  | meaning
// S_REQ  | request pc on the bus (or flag a misaligned pc)
// S_WAIT | address accepted, waiting for read data
// S_HOLD | instruction presented, waiting for IF/ID to take it
module if_fetch_stage
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        if_stall_i,
  input  logic        exc_flush_i,
  input  logic [31:0] exc_pc_i,
  input  logic        id_do_branch_i,
  input  logic [31:0] id_branch_addr_i,
  input  logic        id_jump_flag_i,
  input  logic [25:0] id_jump_index_i,
  input  logic        id_jr_flag_i,
  input  logic [31:0] id_rs_data_i,
  input  logic [31:0] id_pc4_i,
  output logic        inst_req_o,
  output logic [31:0] inst_addr_o,
  input  logic        inst_addr_ok_i,
  input  logic        inst_data_ok_i,
  input  logic [31:0] inst_rdata_i,
  output logic        if_valid_o,
  output logic [31:0] if_instr_o,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_pc4_o,
  output logic        if_adel_o,
  output logic        fetch_busy_o
);

  fetch_state_t state, state_nxt;
  logic [31:0]  pc, pc_nxt;
  logic [31:0]  instr, instr_nxt;
  logic         valid, valid_nxt;
  logic         adel, adel_nxt;
  logic         discard, discard_nxt;
  logic         redir_pend, redir_pend_nxt;
  logic [31:0]  redir_tgt, redir_tgt_nxt;

  logic         redir_hit;
  logic [31:0]  redir_new_tgt;
  logic [31:0]  next_pc;
  logic         misaligned;
  logic         consume;

  next_pc_gen u_next_pc_gen (
    .pc            (pc),
    .stall         (if_stall_i),
    .do_branch     (id_do_branch_i),
    .branch_addr   (id_branch_addr_i),
    .jump_flag     (id_jump_flag_i),
    .jump_index    (id_jump_index_i),
    .jr_flag       (id_jr_flag_i),
    .rs_data       (id_rs_data_i),
    .id_pc4        (id_pc4_i),
    .redir_pend    (redir_pend),
    .redir_tgt     (redir_tgt),
    .redir_hit     (redir_hit),
    .redir_new_tgt (redir_new_tgt),
    .next_pc       (next_pc)
  );

  assign misaligned = (pc[1:0] != 2'b00);
  assign consume    = (state == S_HOLD) & ~if_stall_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= S_REQ;
      pc         <= RESET_PC;
      instr      <= NOP_INSTR;
      valid      <= 1'b0;
      adel       <= 1'b0;
      discard    <= 1'b0;
      redir_pend <= 1'b0;
      redir_tgt  <= 32'h0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      instr      <= instr_nxt;
      valid      <= valid_nxt;
      adel       <= adel_nxt;
      discard    <= discard_nxt;
      redir_pend <= redir_pend_nxt;
      redir_tgt  <= redir_tgt_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    instr_nxt      = instr;
    valid_nxt      = valid;
    adel_nxt       = adel;
    discard_nxt    = discard;
    redir_pend_nxt = redir_pend;
    redir_tgt_nxt  = redir_tgt;

    // Remember a redirect until its delay slot has been handed over.
    if (redir_hit && !consume) begin
      redir_pend_nxt = 1'b1;
      redir_tgt_nxt  = redir_new_tgt;
    end

    case (state)
      S_REQ: begin
        if (misaligned) begin
          valid_nxt = 1'b1;
          adel_nxt  = 1'b1;
          instr_nxt = NOP_INSTR;
          state_nxt = S_HOLD;
        end else if (inst_addr_ok_i) begin
          if (inst_data_ok_i) begin
            valid_nxt = 1'b1;
            adel_nxt  = 1'b0;
            instr_nxt = inst_rdata_i;
            state_nxt = S_HOLD;
          end else begin
            state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (inst_data_ok_i) begin
          if (discard) begin
            discard_nxt = 1'b0;
            state_nxt   = S_REQ;
          end else begin
            valid_nxt = 1'b1;
            adel_nxt  = 1'b0;
            instr_nxt = inst_rdata_i;
            state_nxt = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (!if_stall_i) begin
          pc_nxt         = next_pc;
          valid_nxt      = 1'b0;
          adel_nxt       = 1'b0;
          instr_nxt      = NOP_INSTR;
          redir_pend_nxt = 1'b0;
          state_nxt      = S_REQ;
        end
      end
      default: state_nxt = S_REQ;
    endcase

    // Exception redirect wins over everything above. A fetch already
    // accepted by the bus must still be drained, so its data is marked
    // for discard rather than abandoned.
    if (exc_flush_i) begin
      pc_nxt         = exc_pc_i;
      valid_nxt      = 1'b0;
      adel_nxt       = 1'b0;
      instr_nxt      = NOP_INSTR;
      redir_pend_nxt = 1'b0;
      redir_tgt_nxt  = redir_tgt;
      case (state)
        S_REQ: begin
          if (!misaligned && inst_addr_ok_i && !inst_data_ok_i) begin
            state_nxt   = S_WAIT;
            discard_nxt = 1'b1;
          end else begin
            state_nxt   = S_REQ;
            discard_nxt = 1'b0;
          end
        end
        S_WAIT: begin
          if (inst_data_ok_i) begin
            state_nxt   = S_REQ;
            discard_nxt = 1'b0;
          end else begin
            state_nxt   = S_WAIT;
            discard_nxt = 1'b1;
          end
        end
        default: begin
          state_nxt   = S_REQ;
          discard_nxt = 1'b0;
        end
      endcase
    end
  end

  assign inst_req_o   = (state == S_REQ) & ~misaligned & ~rst_i;
  assign inst_addr_o  = pc;
  assign if_valid_o   = valid;
  assign if_instr_o   = instr;
  assign if_pc_o      = pc;
  assign if_pc4_o     = pc + 32'd4;
  assign if_adel_o    = adel;
  assign fetch_busy_o = (state != S_HOLD) & ~rst_i;

endmodule
